hub75_row_capture: RTL and testbench

- Receive-side counterpart of the LED-matrix panel driver: samples the serial panel bus (red, green, step, latch, addr0/1/2/4, output_enable) and rebuilds each latched row as parallel 32-bit red/green words.
- Each row is delivered on a valid/ready port with its row address.
- Used as the in-fabric checker/loopback target for the driver, and as the panel model in benches.

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_sync_edge.sv | 47 ++++
 rtl/hub75_row_capture.sv | 162 ++++++++++++++++
 tb/tb_hub75_row_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// ============================================================================
// Module   : hub75_pkg
// Brief    : Shared sizes and the captured-row record for hub75_row_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub75_pkg;

    localparam int WIDTH    = 32;
    localparam int ROWS     = 16;
    localparam int ROW_BITS = 4;
    localparam int CNT_BITS = 6;

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(WIDTH + 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    typedef struct packed {
        logic [ROW_BITS-1:0] addr;
        logic [WIDTH-1:0]    red;
        logic [WIDTH-1:0]    green;
        logic                short_row;
    } row_t;

endpackage

`default_nettype wire

// File: rtl/hub75_sync_edge.sv
// ============================================================================
// Module   : hub75_sync_edge
// Brief    : Synchroniser with rising-edge pulse, held off until the chain settles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    localparam int                  ARM_BITS = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_BITS-1:0] ARM_DONE = ARM_BITS'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [ARM_BITS-1:0]    arm_cnt_q;
    logic                   w_level;
    logic                   w_armed;

    assign w_level = sync_q[SYNC_STAGES-1];
    assign w_armed = (arm_cnt_q == ARM_DONE);
    // Arming waits until prev_q has caught up with any level present at release.
    assign rise_o  = w_armed & w_level & ~prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
            prev_q <= w_level;
            if (!w_armed) begin
                arm_cnt_q <= arm_cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hub75_row_capture.sv
// ============================================================================
// Module   : hub75_row_capture
// Brief    : Samples a HUB75 serial panel bus and presents each latched row
//            as parallel red/green words on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_row_capture
    import hub75_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                red,
    input  logic                green,
    input  logic                step,
    input  logic                latch,
    input  logic                addr0,
    input  logic                addr1,
    input  logic                addr2,
    input  logic                addr4,
    input  logic                output_enable,
    input  logic                clear_status,
    output logic                row_valid,
    input  logic                row_ready,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [WIDTH-1:0]    row_red,
    output logic [WIDTH-1:0]    row_green,
    output logic                short_row,
    output logic                overrun,
    output logic [15:0]         frame_count,
    output logic                oe_sync
);

    localparam int BUS_BITS = 7;

    logic [BUS_BITS-1:0] bus_sync_q [SYNC_STAGES];
    logic [BUS_BITS-1:0] w_bus_raw;
    logic [BUS_BITS-1:0] w_bus_s;
    logic                w_step_rise;
    logic                w_latch_rise;
    logic                w_xfer;
    row_t                w_cand;

    logic [WIDTH-1:0]    red_sr_q,    red_sr_d;
    logic [WIDTH-1:0]    green_sr_q,  green_sr_d;
    logic [CNT_BITS-1:0] bit_cnt_q,   bit_cnt_d;
    row_t                hold_q,      hold_d;
    logic                valid_q,     valid_d;
    logic                overrun_q,   overrun_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    assign w_bus_raw = {output_enable, addr4, addr2, addr1, addr0, green, red};
    assign w_bus_s   = bus_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                bus_sync_q[i] <= '0;
            end
        end else begin
            bus_sync_q[0] <= w_bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bus_sync_q[i] <= bus_sync_q[i-1];
            end
        end
    end

    hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (step),
        .rise_o (w_step_rise)
    );

    hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (latch),
        .rise_o (w_latch_rise)
    );

    always_comb begin
        red_sr_d    = red_sr_q;
        green_sr_d  = green_sr_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        w_xfer      = valid_q & row_ready;

        if (w_step_rise) begin
            red_sr_d   = {w_bus_s[0], red_sr_q[WIDTH-1:1]};
            green_sr_d = {w_bus_s[1], green_sr_q[WIDTH-1:1]};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Candidate sees the post-shift state so a coincident step is included.
        w_cand.addr      = w_bus_s[5:2];
        w_cand.red       = red_sr_d;
        w_cand.green     = green_sr_d;
        w_cand.short_row = (bit_cnt_d != CNT_FULL);

        if (w_xfer) begin
            valid_d = 1'b0;
            if (hold_q.addr == LAST_ROW) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        if (clear_status) begin
            overrun_d = 1'b0;
        end

        if (w_latch_rise) begin
            bit_cnt_d = '0;
            if (!valid_q || row_ready) begin
                hold_d  = w_cand;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_sr_q    <= '0;
            green_sr_q  <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            red_sr_q    <= red_sr_d;
            green_sr_q  <= green_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign row_valid   = valid_q;
    assign row_addr    = hold_q.addr;
    assign row_red     = hold_q.red;
    assign row_green   = hold_q.green;
    assign short_row   = hold_q.short_row;
    assign overrun     = overrun_q;
    assign frame_count = frame_cnt_q;
    assign oe_sync     = w_bus_s[6];

endmodule

`default_nettype wire

// File: tb/tb_hub75_row_capture.sv
// ============================================================================
// Module   : tb_hub75_row_capture
// Brief    : Directed + randomized bench; expected rows come from a bit-history model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hub75_row_capture;
    import hub75_pkg::*;

    logic clk = 1'b0;
    logic reset, red, green, step, latch, addr0, addr1, addr2, addr4;
    logic output_enable, clear_status, row_ready;
    logic                row_valid;
    logic [ROW_BITS-1:0] row_addr;
    logic [WIDTH-1:0]    row_red, row_green;
    logic                short_row, overrun, oe_sync;
    logic [15:0]         frame_count;

    hub75_row_capture #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .red(red), .green(green), .step(step),
        .latch(latch), .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .addr4(addr4), .output_enable(output_enable),
        .clear_status(clear_status), .row_valid(row_valid),
        .row_ready(row_ready), .row_addr(row_addr), .row_red(row_red),
        .row_green(row_green), .short_row(short_row), .overrun(overrun),
        .frame_count(frame_count), .oe_sync(oe_sync)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: every bit ever shifted since reset (seeded with WIDTH zeros).
    bit   hist_r[$];
    bit   hist_g[$];
    int   since_latch;
    int   exp_frames;
    logic [ROW_BITS-1:0] exp_addr;
    logic [WIDTH-1:0]    exp_red, exp_green;
    logic                exp_short;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_r.delete();
        hist_g.delete();
        for (int i = 0; i < WIDTH; i++) begin
            hist_r.push_back(1'b0);
            hist_g.push_back(1'b0);
        end
        since_latch = 0;
        exp_frames  = 0;
    endtask

    task automatic predict(input logic [ROW_BITS-1:0] a);
        int base;
        base     = hist_r.size() - WIDTH;
        exp_addr = a;
        for (int i = 0; i < WIDTH; i++) begin
            exp_red[i]   = hist_r[base + i];
            exp_green[i] = hist_g[base + i];
        end
        exp_short   = (since_latch != WIDTH);
        since_latch = 0;
    endtask

    task automatic shift_bit(input logic r, input logic g);
        red   = r;
        green = g;
        step  = 1'b1;
        tick(3);
        step  = 1'b0;
        tick(3);
        hist_r.push_back(r);
        hist_g.push_back(g);
        since_latch++;
    endtask

    task automatic shift_word(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] g);
        for (int i = 0; i < WIDTH; i++) shift_bit(r[i], g[i]);
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift_bit(1'($urandom), 1'($urandom));
    endtask

    task automatic set_addr(input logic [ROW_BITS-1:0] a);
        {addr4, addr2, addr1, addr0} = a;
    endtask

    task automatic check_row(input string tag);
        check({tag, "_addr"},  64'(row_addr),  64'(exp_addr));
        check({tag, "_red"},   64'(row_red),   64'(exp_red));
        check({tag, "_green"}, 64'(row_green), 64'(exp_green));
        check({tag, "_short"}, 64'(short_row), 64'(exp_short));
    endtask

    // Latch into an empty holding register with row_ready high; expects a one-cycle pulse.
    task automatic latch_xfer(input logic [ROW_BITS-1:0] a, input string tag);
        bit found;
        found = 1'b0;
        set_addr(a);
        tick(3);
        latch = 1'b1;
        predict(a);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (row_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 64'(found), 64'd1);
        if (found) begin
            check_row(tag);
            if (a == LAST_ROW) exp_frames++;
            tick(1);
            check({tag, "_drop"}, 64'(row_valid), 64'd0);
        end
        latch = 1'b0;
        tick(3);
    endtask

    logic [ROW_BITS-1:0] a_addr;
    logic [WIDTH-1:0]    a_red, a_green;
    int                  nbits;

    initial begin
        reset = 1'b1; red = 0; green = 0; step = 0; latch = 0;
        addr0 = 0; addr1 = 0; addr2 = 0; addr4 = 0;
        output_enable = 0; clear_status = 0; row_ready = 1'b1;
        model_reset();
        tick(3);
        check("rst_valid",   64'(row_valid),   64'd0);
        check("rst_addr",    64'(row_addr),    64'd0);
        check("rst_red",     64'(row_red),     64'd0);
        check("rst_green",   64'(row_green),   64'd0);
        check("rst_short",   64'(short_row),   64'd0);
        check("rst_overrun", 64'(overrun),     64'd0);
        check("rst_frames",  64'(frame_count), 64'd0);
        check("rst_oe",      64'(oe_sync),     64'd0);
        reset = 1'b0;
        tick(5);

        output_enable = 1'b1; tick(3);
        check("oe_high", 64'(oe_sync), 64'd1);
        output_enable = 1'b0; tick(3);
        check("oe_low", 64'(oe_sync), 64'd0);

        shift_word(32'hA5A5_0F0F, 32'h1234_5678);
        latch_xfer(4'd5, "full");

        shift_rand(31);
        latch_xfer(4'($urandom_range(0, 14)), "short31");
        shift_rand(40);
        latch_xfer(4'($urandom_range(0, 14)), "long40");

        // Back-pressure: row 3 held, row 4 dropped.
        row_ready = 1'b0;
        shift_word($urandom, $urandom);
        set_addr(4'd3); tick(3); latch = 1'b1; tick(4);
        predict(4'd3);
        a_addr = exp_addr; a_red = exp_red; a_green = exp_green;
        check("hold_valid", 64'(row_valid), 64'd1);
        check_row("hold");
        latch = 1'b0; tick(3);
        shift_word($urandom, $urandom);
        set_addr(4'd4); tick(3); latch = 1'b1; tick(4);
        predict(4'd4);
        check("ovr_valid", 64'(row_valid), 64'd1);
        check("ovr_addr",  64'(row_addr),  64'(a_addr));
        check("ovr_red",   64'(row_red),   64'(a_red));
        check("ovr_green", 64'(row_green), 64'(a_green));
        check("ovr_flag",  64'(overrun),   64'd1);
        latch = 1'b0; tick(3);
        clear_status = 1'b1; tick(1); clear_status = 1'b0;
        check("clr_flag", 64'(overrun), 64'd0);

        // Ready arrives in the capture cycle: transfer and reload back to back.
        shift_word($urandom, $urandom);
        set_addr(4'd4); tick(3); latch = 1'b1; tick(2);
        check("b2b_pre_valid", 64'(row_valid), 64'd1);
        check("b2b_pre_addr",  64'(row_addr),  64'(a_addr));
        row_ready = 1'b1; tick(1);
        predict(4'd4);
        check("b2b_valid", 64'(row_valid), 64'd1);
        check_row("b2b");
        check("b2b_overrun", 64'(overrun), 64'd0);
        tick(1);
        check("b2b_drop", 64'(row_valid), 64'd0);
        latch = 1'b0; tick(3);

        for (int i = 0; i < 6; i++) begin
            nbits = $urandom_range(28, 36);
            shift_rand(nbits);
            latch_xfer(4'($urandom_range(0, 14)), "rand");
        end

        check("frames_before", 64'(frame_count), 64'(exp_frames));
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                shift_word($urandom, $urandom);
                latch_xfer(4'(r), "frame");
            end
        end
        check("frames_after", 64'(frame_count), 64'(exp_frames));
        check("frames_three", 64'(exp_frames), 64'd3);

        // Step held high across reset release must not count as a shift.
        reset = 1'b1; step = 1'b1; tick(3);
        model_reset();
        reset = 1'b0; tick(6);
        step = 1'b0; tick(3);
        check("rel_valid",  64'(row_valid),   64'd0);
        check("rel_frames", 64'(frame_count), 64'd0);
        shift_word($urandom, $urandom);
        latch_xfer(4'd7, "rel");

        // Reset mid-row discards the held row and partial shift state.
        row_ready = 1'b0;
        shift_word($urandom, $urandom);
        set_addr(4'd9); tick(3); latch = 1'b1; tick(4);
        predict(4'd9);
        check("mid_hold", 64'(row_valid), 64'd1);
        latch = 1'b0; tick(3);
        shift_rand(10);
        reset = 1'b1; tick(2);
        check("mid_valid", 64'(row_valid), 64'd0);
        reset = 1'b0;
        model_reset();
        tick(5);
        row_ready = 1'b1;
        shift_word($urandom, $urandom);
        latch_xfer(4'd2, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
